// File: rtl/sys_signal_pkg.sv
// sys_signal_pkg: shared types and helpers for the system-signal generator
package sys_signal_pkg;
  localparam int CNT_W_DEF = 8;
  typedef enum logic {HOLD, RUN} state_t;
  typedef logic [CNT_W_DEF-1:0] cnt_t;
  function automatic int hold_w(input int rst_hold);
    return $clog2(rst_hold + 1);
  endfunction
endpackage

// File: rtl/sys_signal_ch.sv
// sys_signal_ch: one divided-clock/strobe channel with configuration latched at load
module sys_signal_ch #(
  parameter int CNT_W = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             run,
  input  logic             en,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] phase,
  output logic             active,
  output logic             tick,
  output logic             div
);
  logic [CNT_W-1:0] cnt, p_q;
  assign tick = active & (cnt == p_q - 1'b1);
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      active <= 1'b0;
      cnt    <= '0;
      p_q    <= '0;
      div    <= 1'b0;
    end else if (run & en & !active) begin
      p_q    <= period;
      cnt    <= (phase < period) ? phase : '0;
      active <= (period != '0);
    end else if (active & en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
      div <= tick ? ~div : div;
    end else if (active) begin
      active <= 1'b0;
      cnt    <= '0;
      div    <= 1'b0;
    end
  end
endmodule

// File: rtl/sys_signal_gen.sv
// sys_signal_gen: stretched reset release plus NUM_CH programmable divided clocks/strobes
module sys_signal_gen
  import sys_signal_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int CNT_W    = 8,
  parameter int RST_HOLD = 4
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH*CNT_W-1:0] ch_period,
  input  logic [NUM_CH*CNT_W-1:0] ch_phase,
  output logic                    rst_out,
  output logic                    run,
  output logic [NUM_CH-1:0]       ch_active,
  output logic [NUM_CH-1:0]       ch_tick,
  output logic [NUM_CH-1:0]       ch_div
);
  localparam int HW = hold_w(RST_HOLD);
  state_t state, state_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic hold_done;
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state    <= HOLD;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      hold_cnt <= hold_n;
    end
  end
  always_comb begin
    hold_done = (hold_cnt == HW'(RST_HOLD - 1));
    state_n   = (state == HOLD && hold_done) ? RUN : state;
    hold_n    = (state == HOLD && !hold_done) ? hold_cnt + HW'(1) : hold_cnt;
  end
  assign rst_out = (state == HOLD);
  assign run     = (state == RUN);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    sys_signal_ch #(.CNT_W(CNT_W)) u_ch (
      .sys_clk(sys_clk),
      .sys_rst(sys_rst),
      .run    (run),
      .en     (ch_en[i]),
      .period (ch_period[i*CNT_W +: CNT_W]),
      .phase  (ch_phase[i*CNT_W +: CNT_W]),
      .active (ch_active[i]),
      .tick   (ch_tick[i]),
      .div    (ch_div[i])
    );
  end
endmodule
